// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes, FSM states and datapath width.
// Also used by the ALU decoder, so the code values are fixed.
package alu_pkg;

  localparam int XLEN = 32;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_SLT  = 4'b0010,
    ALU_SLTU = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_OR   = 4'b0101,
    ALU_AND  = 4'b0110,
    ALU_SLL  = 4'b0111,
    ALU_SRL  = 4'b1000,
    ALU_SRA  = 4'b1001
  } alu_op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } alu_state_e;

  function automatic logic is_shift(input logic [3:0] op);
    return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
  endfunction

  // Codes above ALU_SRA have no operation assigned.
  function automatic logic is_defined(input logic [3:0] op);
    return op <= ALU_SRA;
  endfunction

endpackage

// File: rtl/alu_multicycle_if.sv
// Request/response handshake bundle between the ALU and its client.
interface alu_multicycle_if #(
  parameter int XLEN = 32
);

  logic            in_valid;
  logic            in_ready;
  logic [3:0]      alucontrol;
  logic [XLEN-1:0] operand_a;
  logic [XLEN-1:0] operand_b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            illegal;

  modport master (
    output in_valid, alucontrol, operand_a, operand_b, out_ready,
    input  in_ready, out_valid, result, illegal
  );

  modport slave (
    input  in_valid, alucontrol, operand_a, operand_b, out_ready,
    output in_ready, out_valid, result, illegal
  );

endinterface

// File: rtl/alu_core.sv
// Single-cycle ALU operations (add through and). Shifts and undefined
// codes produce zero here; the wrapper handles them.
module alu_core
  import alu_pkg::*;
#(
  parameter int XLEN = alu_pkg::XLEN
) (
  input  alu_op_e         op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] y
);

  logic lt_s;
  logic lt_u;

  assign lt_s = $signed(a) < $signed(b);
  assign lt_u = a < b;

  always_comb begin
    y = '0;
    case (op)
      ALU_ADD:  y = a + b;
      ALU_SUB:  y = a - b;
      ALU_SLT:  y = {{(XLEN-1){1'b0}}, lt_s};
      ALU_SLTU: y = {{(XLEN-1){1'b0}}, lt_u};
      ALU_XOR:  y = a ^ b;
      ALU_OR:   y = a | b;
      ALU_AND:  y = a & b;
      default:  y = '0;
    endcase
  end

endmodule

// File: rtl/alu_multicycle.sv
// Multicycle ALU: single-cycle ops finish in one cycle, shifts run one bit
// per cycle. The result register doubles as the shift working value.
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int XLEN = alu_pkg::XLEN
) (
  input logic             clk,
  input logic             rst,
  alu_multicycle_if.slave bus
);

  alu_state_e      state;
  alu_state_e      state_n;
  alu_op_e         op_q;
  alu_op_e         op_in;
  logic [4:0]      cnt;
  logic [XLEN-1:0] result_q;
  logic            illegal_q;
  logic [XLEN-1:0] core_y;
  logic            accept;

  assign op_in  = alu_op_e'(bus.alucontrol);
  assign accept = bus.in_valid && bus.in_ready;

  alu_core #(.XLEN(XLEN)) u_core (
    .op (op_in),
    .a  (bus.operand_a),
    .b  (bus.operand_b),
    .y  (core_y)
  );

  function automatic logic [XLEN-1:0] shift_one(input alu_op_e op,
                                                input logic [XLEN-1:0] v);
    case (op)
      ALU_SLL: return {v[XLEN-2:0], 1'b0};
      ALU_SRL: return {1'b0, v[XLEN-1:1]};
      default: return {v[XLEN-1], v[XLEN-1:1]};
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: begin
        if (accept)
          state_n = (is_shift(bus.alucontrol) && bus.operand_b[4:0] != 5'd0)
                    ? S_SHIFT : S_DONE;
      end
      // Leave SHIFT on the edge that takes the count to zero.
      S_SHIFT: if (cnt == 5'd1) state_n = S_DONE;
      S_DONE:  if (bus.out_ready) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q      <= ALU_ADD;
      cnt       <= 5'd0;
      result_q  <= '0;
      illegal_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            op_q <= op_in;
            cnt  <= bus.operand_b[4:0];
            if (is_shift(bus.alucontrol)) begin
              // Seeds the working value; a zero count leaves it as the result.
              result_q  <= bus.operand_a;
              illegal_q <= 1'b0;
            end else if (!is_defined(bus.alucontrol)) begin
              result_q  <= '0;
              illegal_q <= 1'b1;
            end else begin
              result_q  <= core_y;
              illegal_q <= 1'b0;
            end
          end
        end
        S_SHIFT: begin
          result_q <= shift_one(op_q, result_q);
          cnt      <= cnt - 5'd1;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state == S_IDLE) && !rst;
  assign bus.out_valid = (state == S_DONE);
  assign bus.result    = result_q;
  assign bus.illegal   = illegal_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Randomized scoreboard bench for alu_multicycle: the driver queues expected
// results from an arithmetic model, a monitor pops and checks each output.
module tb_alu_multicycle;

  typedef struct {
    logic [31:0] res;
    logic        ill;
    int          lat;
    int          acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  int   bp_mode = 0;
  exp_t expq[$];
  exp_t cur;
  logic have_cur = 1'b0;

  alu_multicycle_if #(.XLEN(32)) ifc ();

  alu_multicycle #(.XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic [3:0] op, input logic [31:0] a,
                                 input logic [31:0] b);
    exp_t m;
    int sh;
    sh    = int'(b % 32);
    m.ill = 1'b0;
    m.lat = 1;
    m.acc = 0;
    case (op)
      4'd0: m.res = a + b;
      4'd1: m.res = a - b;
      4'd2: m.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd3: m.res = (a < b) ? 32'd1 : 32'd0;
      4'd4: m.res = a ^ b;
      4'd5: m.res = a | b;
      4'd6: m.res = a & b;
      4'd7: m.res = a << sh;
      4'd8: m.res = a >> sh;
      4'd9: m.res = $signed(a) >>> sh;
      default: begin m.res = 32'd0; m.ill = 1'b1; end
    endcase
    if (op >= 4'd7 && op <= 4'd9) m.lat = sh + 1;
    return m;
  endfunction

  // Consumer side: random backpressure unless a test pins out_ready.
  initial begin
    ifc.out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (bp_mode)
        0:       ifc.out_ready = ($urandom % 4) != 0;
        1:       ifc.out_ready = 1'b0;
        default: ifc.out_ready = 1'b1;
      endcase
    end
  end

  // Monitor: compare on the first cycle each result is presented, then
  // require it to stay put until the handshake.
  always @(negedge clk) begin
    if (rst) begin
      have_cur = 1'b0;
    end else if (ifc.out_valid) begin
      if (!have_cur) begin
        if (expq.size() == 0) begin
          chk("unexpected_out_valid", 64'(ifc.out_valid), 64'd0);
          cur = '{res: ifc.result, ill: ifc.illegal, lat: 0, acc: 0};
        end else begin
          cur = expq.pop_front();
          chk("result", 64'(ifc.result), 64'(cur.res));
          chk("illegal", 64'(ifc.illegal), 64'(cur.ill));
          chk("latency", 64'(cyc - cur.acc + 1), 64'(cur.lat));
        end
        have_cur = 1'b1;
      end else begin
        chk("hold_result", 64'(ifc.result), 64'(cur.res));
        chk("hold_illegal", 64'(ifc.illegal), 64'(cur.ill));
      end
      if (ifc.out_ready) have_cur = 1'b0;
    end else if (have_cur) begin
      chk("out_valid_dropped", 64'(ifc.out_valid), 64'd1);
      have_cur = 1'b0;
    end
  end

  task automatic scramble();
    ifc.alucontrol = 4'($urandom);
    ifc.operand_a  = $urandom;
    ifc.operand_b  = $urandom;
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    int   n;
    @(negedge clk);
    ifc.alucontrol = op;
    ifc.operand_a  = a;
    ifc.operand_b  = b;
    ifc.in_valid   = 1'b1;
    n = 0;
    while (!ifc.in_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!ifc.in_ready) begin
      chk("issue_timeout", 64'(ifc.in_ready), 64'd1);
      ifc.in_valid = 1'b0;
      return;
    end
    e     = model(op, a, b);
    e.acc = cyc + 1;
    expq.push_back(e);
    @(posedge clk);
    #1;
    ifc.in_valid = 1'b0;
    scramble();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((expq.size() != 0 || have_cur) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", 64'(expq.size()), 64'd0);
  endtask

  initial begin
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          n;

    ifc.in_valid = 1'b0;
    scramble();
    repeat (3) @(negedge clk);
    chk("reset_out_valid", 64'(ifc.out_valid), 64'd0);
    chk("reset_result", 64'(ifc.result), 64'd0);
    chk("reset_illegal", 64'(ifc.illegal), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_in_ready", 64'(ifc.in_ready), 64'd1);

    // Directed corner cases.
    bp_mode = 2;
    issue(4'd0, 32'h7FFF_FFFF, 32'd1);
    issue(4'd2, 32'hFFFF_FFFF, 32'd1);
    issue(4'd3, 32'hFFFF_FFFF, 32'd1);
    issue(4'd15, $urandom, $urandom);
    issue(4'd7, 32'hDEAD_BEEF, 32'h20);
    drain();

    // Long sra with ignored in_valid pulses while busy.
    issue(4'd9, 32'h8000_0000, 32'd31);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("busy_in_ready", 64'(ifc.in_ready), 64'd0);
      ifc.in_valid   = 1'b1;
      ifc.alucontrol = 4'd0;
    end
    @(negedge clk);
    ifc.in_valid = 1'b0;
    drain();

    // Backpressure: result must be held across 10 stalled cycles.
    bp_mode = 1;
    issue(4'd7, 32'd1, 32'd4);
    n = 0;
    while (!ifc.out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (10) @(negedge clk);
    chk("bp_out_valid", 64'(ifc.out_valid), 64'd1);
    chk("bp_result", 64'(ifc.result), 64'h10);
    chk("bp_in_ready", 64'(ifc.in_ready), 64'd0);
    bp_mode = 2;
    n = 0;
    while (!ifc.out_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk("bp_release_in_ready", 64'(ifc.in_ready), 64'd1);
    chk("bp_release_out_valid", 64'(ifc.out_valid), 64'd0);

    // Reset in the middle of a shift aborts it without a stale result.
    issue(4'd8, 32'hF0F0_1234, 32'd20);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    expq.delete();
    @(negedge clk);
    chk("midreset_out_valid", 64'(ifc.out_valid), 64'd0);
    chk("midreset_result", 64'(ifc.result), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset_in_ready", 64'(ifc.in_ready), 64'd1);
    n = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (ifc.out_valid) n++;
    end
    chk("post_reset_no_out_valid", 64'(n), 64'd0);
    issue(4'd0, 32'd100, 32'd23);
    drain();

    // Random traffic with random backpressure.
    bp_mode = 0;
    for (int i = 0; i < 80; i++) begin
      op = ($urandom % 8 == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      a  = $urandom;
      b  = ($urandom % 2) ? 32'($urandom_range(0, 40)) : $urandom;
      issue(op, a, b);
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_multicycle.md
ALU_MULTICYCLE -- requirements
Module: alu_multicycle

Interface
REQ-001 Parameter: XLEN, 32, operand/result width; only 32 is supported.
REQ-002 clk  input  1  rising-edge clock, the single clock of the block.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 in_valid  input  1  request carries a valid operation.
REQ-005 in_ready  output  1  block can accept a request this cycle.
REQ-006 alucontrol  input  4  operation code from the ALU decoder.
REQ-007 operand_a  input  XLEN  first operand / shift source.
REQ-008 operand_b  input  XLEN  second operand; bits [4:0] are the shift amount for shifts.
REQ-009 out_valid  output  1  result and illegal are valid.
REQ-010 out_ready  input  1  consumer takes the result this cycle.
REQ-011 result  output  XLEN  operation result.
REQ-012 illegal  output  1  alucontrol was an undefined code.

Function
REQ-013 Codes: 0000 add, 0001 sub, 0010 slt (signed), 0011 sltu (unsigned), 0100 xor, 0101 or, 0110 and, 0111 sll, 1000 srl, 1001 sra; 1010-1111 undefined.
REQ-014 FSM states: IDLE, SHIFT, DONE; in_ready SHALL be 1 only in IDLE.
REQ-015 Accept: on a clk edge with in_valid && in_ready, latch alucontrol, operand_a, operand_b, shift count = operand_b[4:0].
REQ-016 Non-shift codes, undefined codes, and shifts with count 0: IDLE -> DONE on the accept edge; out_valid is high in the following cycle (latency 1).
REQ-017 Shift codes with count N>0: IDLE -> SHIFT; each SHIFT cycle shifts the working value by exactly one bit and decrements the count; SHIFT -> DONE on the edge where the count reaches 0; out_valid is high N+1 cycles after the accept edge.
REQ-018 sll fills with 0 at bit 0; srl fills with 0 at bit XLEN-1; sra replicates the current bit XLEN-1.
REQ-019 add/sub wrap modulo 2^XLEN; slt/sltu produce 32'h1 or 32'h0.
REQ-020 Undefined codes: result = 0, illegal = 1; all defined codes: illegal = 0.
REQ-021 DONE: out_valid = 1; result and illegal SHALL be held stable until out_valid && out_ready; DONE -> IDLE on that edge.
REQ-022 in_valid asserted while not in IDLE SHALL be ignored; in_valid with in_ready low does not consume the request.
REQ-023 Operand/alucontrol changes after the accept edge SHALL NOT affect the in-flight result.
REQ-024 out_valid SHALL NOT deassert without a handshake; the result is never lost or duplicated.

Reset
REQ-025 rst asserted SHALL immediately force IDLE, out_valid = 0, result = 0, illegal = 0, and shift count = 0; in_ready = 1 while rst is low and the FSM is in IDLE.
REQ-026 Reset during SHIFT or DONE SHALL abort the operation with no out_valid pulse after release.

Structure
REQ-027 Package alu_pkg SHALL hold the alucontrol code enum (alu_op_e), the FSM state enum, and XLEN; this package is shared with alu_dec.
REQ-028 One sub-module, alu_core, SHALL compute the single-cycle ops (add to and); shifting and handshake logic stay in alu_multicycle.

Verification
REQ-029 add: a=32'h7FFFFFFF, b=1 accepted, out_ready=1 -> one cycle later out_valid=1, result=32'h80000000, illegal=0.
REQ-030 slt vs sltu: a=32'hFFFFFFFF, b=1 -> slt result 1, sltu result 0, each latency 1.
REQ-031 sra: a=32'h80000000, b=31 -> out_valid exactly 32 cycles after accept, result=32'hFFFFFFFF; in_valid pulses during SHIFT are ignored (in_ready=0).
REQ-032 Backpressure: sll a=1, b=4 with out_ready=0 for 10 cycles -> result=32'h10 held stable, out_valid stays 1; DONE -> IDLE on the first out_ready=1 edge.
REQ-033 Undefined code 4'b1111 -> latency 1, result=0, illegal=1; shift with b[4:0]=0 (b=32'h20) -> latency 1, result=a.
REQ-034 Reset mid-SHIFT (srl, b=20, rst at cycle 5) -> out_valid=0, in_ready=1 after release, no stale result; the next add completes correctly.
